// File: rtl/int_pkg.sv
// Shared constants and narrowing helper for the interpolator datapath.
package int_pkg;

  localparam int unsigned INT_IN_W  = 16;
  localparam int unsigned INT_OUT_W = 14;

  // Result of a narrowing: clipped value (sign-extended to 64 bits) and clip indication.
  typedef struct packed {
    logic signed [63:0] value;
    logic               clip;
  } sat_res_t;

  // Clip a sign-extended in_w-bit value to the signed out_w-bit range.
  function automatic sat_res_t sat_narrow(input logic signed [63:0] val,
                                          input int unsigned        in_w,
                                          input int unsigned        out_w);
    sat_res_t           res;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v     = -(64'sd1 <<< (out_w - 1));
    res.value = val;
    res.clip  = 1'b0;
    // Equal widths can never leave the output range.
    if (in_w > out_w) begin
      if (val > max_v) begin
        res.value = max_v;
        res.clip  = 1'b1;
      end else if (val < min_v) begin
        res.value = min_v;
        res.clip  = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/int_out_buffer_if.sv
// Write/read handshake and status bundle of the interpolator output buffer.
interface int_out_buffer_if
  import int_pkg::*;
#(
  parameter int unsigned IN_W  = INT_IN_W,
  parameter int unsigned OUT_W = INT_OUT_W,
  parameter int unsigned DEPTH = 8
);

  logic                       WRITE_EN;
  logic signed [IN_W-1:0]     DATA_IN;
  logic                       IN_READY;
  logic signed [OUT_W-1:0]    DATA_OUT;
  logic                       OUT_VALID;
  logic                       OUT_READY;
  logic [$clog2(DEPTH):0]     COUNT;
  logic                       FULL;
  logic                       EMPTY;
  logic                       SAT_FLAG;
  logic                       CLR_SAT;

  // Producer/consumer side (drives samples and handshake inputs).
  modport master (
    output WRITE_EN, DATA_IN, OUT_READY, CLR_SAT,
    input  IN_READY, DATA_OUT, OUT_VALID, COUNT, FULL, EMPTY, SAT_FLAG
  );

  // Buffer side.
  modport slave (
    input  WRITE_EN, DATA_IN, OUT_READY, CLR_SAT,
    output IN_READY, DATA_OUT, OUT_VALID, COUNT, FULL, EMPTY, SAT_FLAG
  );

endinterface

// File: rtl/int_sat_clip.sv
// Combinational IN_W -> OUT_W signed narrowing, saturating or wrapping.
module int_sat_clip
  import int_pkg::*;
#(
  parameter int unsigned IN_W   = INT_IN_W,
  parameter int unsigned OUT_W  = INT_OUT_W,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic signed [IN_W-1:0]  data_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    clip_o
);

  sat_res_t res;
  logic     unused_res;

  // Select between clipped value and plain low-bit truncation.
  always_comb begin
    res = sat_narrow(64'(data_i), IN_W, OUT_W);
    if (SAT_EN) begin
      data_o = res.value[OUT_W-1:0];
      clip_o = res.clip;
    end else begin
      data_o = data_i[OUT_W-1:0];
      clip_o = 1'b0;
    end
  end

  // Upper bits of the wide result are only sign extension.
  assign unused_res = ^res;

endmodule

// File: rtl/int_out_buffer.sv
// Output FIFO of the interpolator: narrows samples on write, valid/ready on read.
module int_out_buffer
  import int_pkg::*;
#(
  parameter int unsigned IN_W   = INT_IN_W,
  parameter int unsigned OUT_W  = INT_OUT_W,
  parameter int unsigned DEPTH  = 8,
  parameter bit          SAT_EN = 1'b1
) (
  input logic                CLK,
  input logic                RST_SYNC,
  int_out_buffer_if.slave    bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic signed [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [AW:0]             count_q;
  logic                    sat_flag_q;

  logic signed [OUT_W-1:0] conv_data;
  logic                    conv_clip;
  logic                    full;
  logic                    empty;
  logic                    wr_acc;
  logic                    rd_acc;

  int_sat_clip #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SAT_EN (SAT_EN)
  ) u_sat_clip (
    .data_i (bus.DATA_IN),
    .data_o (conv_data),
    .clip_o (conv_clip)
  );

  // Status comes from registered COUNT only, so there is no write-through on a full buffer.
  always_comb begin
    full   = (count_q == (AW + 1)'(DEPTH));
    empty  = (count_q == '0);
    wr_acc = bus.WRITE_EN && !full;
    rd_acc = !empty && bus.OUT_READY;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sample storage; contents are don't-care after reset since the pointers restart.
  always_ff @(posedge CLK) begin
    if (!RST_SYNC && wr_acc) mem_q[wr_ptr_q] <= conv_data;
  end

  // Sticky clip flag; a clip in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RST_SYNC)                sat_flag_q <= 1'b0;
    else if (wr_acc && conv_clip) sat_flag_q <= 1'b1;
    else if (bus.CLR_SAT)        sat_flag_q <= 1'b0;
  end

  // Outputs; DATA_OUT reads the head combinationally and is zeroed when empty.
  always_comb begin
    bus.IN_READY  = !full;
    bus.OUT_VALID = !empty;
    bus.FULL      = full;
    bus.EMPTY     = empty;
    bus.COUNT     = count_q;
    bus.SAT_FLAG  = sat_flag_q;
    bus.DATA_OUT  = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_int_out_buffer.sv
// Randomised, model-checked bench for int_out_buffer (saturating and wrapping builds).
module tb_int_out_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_out_buffer_if #(.IN_W(16), .OUT_W(14), .DEPTH(8)) b  ();
  int_out_buffer_if #(.IN_W(16), .OUT_W(14), .DEPTH(8)) bn ();

  int_out_buffer #(.IN_W(16), .OUT_W(14), .DEPTH(8), .SAT_EN(1'b1)) dut (
    .CLK      (clk),
    .RST_SYNC (rst),
    .bus      (b)
  );

  int_out_buffer #(.IN_W(16), .OUT_W(14), .DEPTH(8), .SAT_EN(1'b0)) dut_ns (
    .CLK      (clk),
    .RST_SYNC (rst),
    .bus      (bn)
  );

  int npass  = 0;
  int ntotal = 0;

  // Reference model: a plain queue of stored sample values plus the sticky flag.
  int q[$];
  bit m_sat;

  function automatic int conv(input int v, input bit sat);
    int w;
    if (sat) begin
      if (v > 8191)  return 8191;
      if (v < -8192) return -8192;
      return v;
    end
    w = v % 16384;
    if (w < 0)     w += 16384;
    if (w >= 8192) w -= 16384;
    return w;
  endfunction

  function automatic int head();
    return (q.size() != 0) ? q[0] : 0;
  endfunction

  // Drive one cycle on the saturating DUT, advance the model, sample 1 ns after the edge.
  task automatic drive(input bit r, input bit we, input int din, input bit ordy, input bit clr);
    bit wacc, racc;
    rst         = r;
    b.WRITE_EN  = we;
    b.DATA_IN   = din[15:0];
    b.OUT_READY = ordy;
    b.CLR_SAT   = clr;
    if (r) begin
      q.delete();
      m_sat = 1'b0;
    end else begin
      wacc = we && (q.size() < 8);
      racc = ordy && (q.size() != 0);
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(conv(din, 1'b1));
      if (wacc && (din > 8191 || din < -8192)) m_sat = 1'b1;
      else if (clr) m_sat = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int got;
    drive(1, 1, 1234, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    got = b.DATA_OUT;
    ntotal++; if (b.EMPTY !== 1'b1) $display("FAIL reset_empty got %b want 1", b.EMPTY); else npass++;
    ntotal++; if (b.OUT_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", b.OUT_VALID); else npass++;
    ntotal++; if (got !== 0) $display("FAIL reset_data got %0d want 0", got); else npass++;
    ntotal++; if (b.COUNT !== 4'd0) $display("FAIL reset_count got %0d want 0", b.COUNT); else npass++;
    ntotal++; if (b.IN_READY !== 1'b1) $display("FAIL reset_in_ready got %b want 1", b.IN_READY); else npass++;
    ntotal++; if (b.SAT_FLAG !== 1'b0) $display("FAIL reset_sat got %b want 0", b.SAT_FLAG); else npass++;
    ntotal++; if (bn.EMPTY !== 1'b1) $display("FAIL reset_ns_empty got %b want 1", bn.EMPTY); else npass++;
  endtask

  task automatic test_fill_drain();
    int got;
    for (int i = 1; i <= 8; i++) drive(0, 1, i, 0, 0);
    ntotal++; if (b.FULL !== 1'b1) $display("FAIL fill_full got %b want 1", b.FULL); else npass++;
    ntotal++; if (b.IN_READY !== 1'b0) $display("FAIL fill_in_ready got %b want 0", b.IN_READY); else npass++;
    drive(0, 1, 99, 0, 0);
    ntotal++; if (b.COUNT !== 4'd8) $display("FAIL fill_drop_count got %0d want 8", b.COUNT); else npass++;
    for (int i = 1; i <= 8; i++) begin
      got = b.DATA_OUT;
      ntotal++; if (got !== i) $display("FAIL drain_order got %0d want %0d", got, i); else npass++;
      ntotal++;
      if (b.COUNT !== 4'(9 - i)) $display("FAIL drain_count got %0d want %0d", b.COUNT, 9 - i);
      else npass++;
      drive(0, 0, 0, 1, 0);
    end
    ntotal++; if (b.EMPTY !== 1'b1) $display("FAIL drain_empty got %b want 1", b.EMPTY); else npass++;
  endtask

  task automatic test_saturation();
    int got;
    drive(0, 1, 9000, 0, 0);
    ntotal++; if (b.SAT_FLAG !== 1'b1) $display("FAIL sat_set got %b want 1", b.SAT_FLAG); else npass++;
    drive(0, 1, -9000, 0, 0);
    drive(0, 1, 8191, 0, 0);
    drive(0, 1, 9000, 0, 1);
    ntotal++; if (b.SAT_FLAG !== 1'b1) $display("FAIL sat_set_wins got %b want 1", b.SAT_FLAG); else npass++;
    drive(0, 0, 0, 0, 1);
    ntotal++; if (b.SAT_FLAG !== 1'b0) $display("FAIL sat_clear got %b want 0", b.SAT_FLAG); else npass++;
    // Rejected clipping write must not set the flag: fill to full first.
    for (int i = 0; i < 4; i++) drive(0, 1, 5, 0, 0);
    drive(0, 1, -30000, 0, 0);
    ntotal++; if (b.SAT_FLAG !== 1'b0) $display("FAIL sat_rejected got %b want 0", b.SAT_FLAG); else npass++;
    for (int i = 0; i < 8; i++) begin
      got = b.DATA_OUT;
      ntotal++; if (got !== head()) $display("FAIL sat_value got %0d want %0d", got, head()); else npass++;
      drive(0, 0, 0, 1, 0);
    end
    // Wrapping build: 0x2001 keeps its low 14 bits, i.e. -8191.
    bn.WRITE_EN = 1'b1;
    bn.DATA_IN  = 16'sh2001;
    @(posedge clk);
    #1;
    bn.WRITE_EN = 1'b0;
    got = bn.DATA_OUT;
    ntotal++; if (got !== -8191) $display("FAIL trunc_value got %0d want -8191", got); else npass++;
    ntotal++; if (bn.SAT_FLAG !== 1'b0) $display("FAIL trunc_sat got %b want 0", bn.SAT_FLAG); else npass++;
    bn.OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    bn.OUT_READY = 1'b0;
  endtask

  task automatic test_simultaneous();
    int got;
    for (int i = 0; i < 3; i++) drive(0, 1, 100 + i, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 200 + i, 1, 0);
      got = b.DATA_OUT;
      ntotal++; if (b.COUNT !== 4'd3) $display("FAIL rw_count got %0d want 3", b.COUNT); else npass++;
      ntotal++; if (got !== head()) $display("FAIL rw_order got %0d want %0d", got, head()); else npass++;
    end
    for (int i = 0; i < 5; i++) drive(0, 1, 300 + i, 0, 0);
    drive(0, 1, 777, 1, 0);
    ntotal++; if (b.COUNT !== 4'd7) $display("FAIL full_rw_count got %0d want 7", b.COUNT); else npass++;
    while (q.size() != 0) begin
      got = b.DATA_OUT;
      ntotal++; if (got !== head()) $display("FAIL full_rw_data got %0d want %0d", got, head()); else npass++;
      drive(0, 0, 0, 1, 0);
    end
    drive(0, 1, 55, 1, 0);
    ntotal++; if (b.COUNT !== 4'd1) $display("FAIL empty_rw_count got %0d want 1", b.COUNT); else npass++;
    ntotal++; if (b.OUT_VALID !== 1'b1) $display("FAIL empty_rw_valid got %b want 1", b.OUT_VALID); else npass++;
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    int got, prev, din;
    bit stalled, we, ordy;
    stalled = 1'b0;
    prev    = 0;
    for (int i = 0; i < 400; i++) begin
      we   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 1) == 1);
      din  = int'($urandom_range(0, 65535)) - 32768;
      drive(0, we, din, ordy, 0);
      got = b.DATA_OUT;
      ntotal++; if (got !== head()) $display("FAIL bp_data got %0d want %0d", got, head()); else npass++;
      ntotal++;
      if (b.COUNT !== 4'(q.size())) $display("FAIL bp_count got %0d want %0d", b.COUNT, q.size());
      else npass++;
      ntotal++; if (b.SAT_FLAG !== m_sat) $display("FAIL bp_sat got %b want %b", b.SAT_FLAG, m_sat); else npass++;
      if (stalled) begin
        ntotal++; if (got !== prev) $display("FAIL bp_hold got %0d want %0d", got, prev); else npass++;
      end
      // Next cycle's head must match this one if the head is not consumed.
      stalled = (q.size() != 0);
      prev    = got;
      b.OUT_READY = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        drive(0, 0, 0, 0, 0);
        got = b.DATA_OUT;
        if (stalled) begin
          ntotal++; if (got !== prev) $display("FAIL bp_stall got %0d want %0d", got, prev); else npass++;
        end
        prev = got;
      end
      stalled = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int got;
    while (q.size() != 0) drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 10 + i, 0, 0);
    ntotal++; if (b.COUNT !== 4'd5) $display("FAIL mid_pre_count got %0d want 5", b.COUNT); else npass++;
    drive(1, 1, 66, 1, 1);
    ntotal++; if (b.COUNT !== 4'd0) $display("FAIL mid_count got %0d want 0", b.COUNT); else npass++;
    ntotal++; if (b.EMPTY !== 1'b1) $display("FAIL mid_empty got %b want 1", b.EMPTY); else npass++;
    drive(0, 1, 42, 0, 0);
    got = b.DATA_OUT;
    ntotal++; if (got !== 42) $display("FAIL mid_first got %0d want 42", got); else npass++;
    ntotal++; if (b.OUT_VALID !== 1'b1) $display("FAIL mid_valid got %b want 1", b.OUT_VALID); else npass++;
  endtask

  initial begin
    rst          = 1'b1;
    b.WRITE_EN   = 1'b0;
    b.DATA_IN    = '0;
    b.OUT_READY  = 1'b0;
    b.CLR_SAT    = 1'b0;
    bn.WRITE_EN  = 1'b0;
    bn.DATA_IN   = '0;
    bn.OUT_READY = 1'b0;
    bn.CLR_SAT   = 1'b0;
    m_sat        = 1'b0;
    test_reset();
    test_fill_drain();
    test_saturation();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
